// File: rtl/serial_frame_pkg.sv
// Shared types and line-level constants for the serial frame receiver.
package serial_frame_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_e;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, DATA_W bits LSB-first, optional parity,
// stop bit. One bit per clock; good words are presented with a one-cycle
// rx_vld pulse, bad frames raise one-cycle par_err / frm_err pulses.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | line idle, waiting for a 0 start bit
//   DATA   | shifting data bits into shreg, LSB first
//   PARITY | sampling parity bit, latching par_bad
//   STOP   | sampling stop bit, issuing rx_vld / par_err / frm_err
module serial_frame_rx
    import serial_frame_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              din,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_vld,
    output logic              par_err,
    output logic              frm_err,
    output logic              busy
);

    localparam int CNT_W = $clog2(DATA_W);

    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_DATA   = DATA;
    localparam logic [1:0] ST_PARITY = PARITY;
    localparam logic [1:0] ST_STOP   = STOP;

    localparam logic       HAS_PAR   = (PARITY_EN != 0);
    localparam logic       ODD_PAR   = (PARITY_ODD != 0);

    logic [1:0]        state;
    logic [DATA_W-1:0] shreg;
    logic [CNT_W-1:0]  bit_cnt;
    logic              par_bad;

    // Frame sequencing, data capture and registered status pulses.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= ST_IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            par_bad <= 1'b0;
            rx_data <= '0;
            rx_vld  <= 1'b0;
            par_err <= 1'b0;
            frm_err <= 1'b0;
        end else begin
            rx_vld  <= 1'b0;
            par_err <= 1'b0;
            frm_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (din == START_BIT) begin
                        state   <= ST_DATA;
                        bit_cnt <= '0;
                        par_bad <= 1'b0;
                    end
                end
                ST_DATA: begin
                    shreg <= {din, shreg[DATA_W-1:1]};
                    // Counter holds on the last bit so it never wraps.
                    if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                        state <= HAS_PAR ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                ST_PARITY: begin
                    par_bad <= HAS_PAR & ((^shreg) ^ din ^ ODD_PAR);
                    state   <= ST_STOP;
                end
                ST_STOP: begin
                    if (din == STOP_BIT) begin
                        if (!par_bad) begin
                            rx_data <= shreg;
                            rx_vld  <= 1'b1;
                        end else begin
                            par_err <= 1'b1;
                        end
                    end else begin
                        frm_err <= 1'b1;
                        par_err <= par_bad;
                    end
                    // Always back to IDLE: a 0 stop bit never starts a frame.
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Busy is a decode of the registered state.
    always_comb begin
        busy = (state != ST_IDLE);
    end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx: default configuration plus a
// DATA_W=5 / no-parity instance, with a scoreboard queue per instance.
module tb_serial_frame_rx;
    import serial_frame_pkg::*;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       din = 1'b1;
    logic       din5 = 1'b1;
    logic [7:0] rx_data;
    logic       rx_vld, par_err, frm_err, busy;
    logic [4:0] rx_data5;
    logic       rx_vld5, par_err5, frm_err5, busy5;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    int vld_cnt = 0, perr_cnt = 0, ferr_cnt = 0, busy_cyc = 0;
    int vld_cyc = 0, prev_vld_cyc = 0;
    int vld5_cnt = 0, perr5_cnt = 0, vld5_cyc = 0;
    int start_cyc = 0;

    logic [31:0] exp_q[$];
    logic [31:0] exp5_q[$];

    serial_frame_rx #(.DATA_W(8), .PARITY_EN(1), .PARITY_ODD(0)) dut (
        .clk(clk), .rstn(rstn), .din(din),
        .rx_data(rx_data), .rx_vld(rx_vld), .par_err(par_err),
        .frm_err(frm_err), .busy(busy)
    );

    serial_frame_rx #(.DATA_W(5), .PARITY_EN(0), .PARITY_ODD(0)) dut5 (
        .clk(clk), .rstn(rstn), .din(din5),
        .rx_data(rx_data5), .rx_vld(rx_vld5), .par_err(par_err5),
        .frm_err(frm_err5), .busy(busy5)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Output monitors: scoreboard pops on rx_vld, event counters otherwise.
    always @(negedge clk) begin
        logic [31:0] e;
        if (rx_vld) begin
            vld_cnt++;
            prev_vld_cyc = vld_cyc;
            vld_cyc = cyc;
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
            check("sb_rx_data", 32'(rx_data), e);
        end
        if (par_err) perr_cnt++;
        if (frm_err) ferr_cnt++;
        if (busy)    busy_cyc++;
    end

    always @(negedge clk) begin
        logic [31:0] e;
        if (rx_vld5) begin
            vld5_cnt++;
            vld5_cyc = cyc;
            e = (exp5_q.size() != 0) ? exp5_q.pop_front() : 32'hDEAD_BEEF;
            check("sb5_rx_data", 32'(rx_data5), e);
        end
        if (par_err5) perr5_cnt++;
    end

    task automatic drive(input logic b);
        @(posedge clk);
        #1 din = b;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(IDLE_LEVEL);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
        drive(START_BIT);
        start_cyc = cyc;
        for (int i = 0; i < 8; i++) drive(d[i]);
        drive(p);
        drive(s);
    endtask

    initial begin
        int v0, p0, f0;
        logic [4:0] d5;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_rx_data", 32'(rx_data), 32'h0);
        check("rst_rx_vld", 32'(rx_vld), 32'h0);
        check("rst_par_err", 32'(par_err), 32'h0);
        check("rst_frm_err", 32'(frm_err), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        rstn = 1'b1;
        idle(3);

        // Good frame 0xA5, even parity 0
        busy_cyc = 0;
        exp_q.push_back(32'hA5);
        send_frame(8'hA5, 1'b0, 1'b1);
        idle(3);
        check("good_vld_cnt", 32'(vld_cnt), 32'd1);
        check("good_latency", 32'(vld_cyc - start_cyc), 32'd11);
        check("good_rx_data", 32'(rx_data), 32'hA5);
        check("good_perr", 32'(perr_cnt), 32'd0);
        check("good_ferr", 32'(ferr_cnt), 32'd0);
        check("good_busy_cycles", 32'(busy_cyc), 32'd10);
        check("good_busy_end", 32'(busy), 32'd0);

        // Parity error: 0x3C has even weight, send parity 1
        send_frame(8'h3C, 1'b1, 1'b1);
        idle(3);
        check("perr_cnt", 32'(perr_cnt), 32'd1);
        check("perr_no_vld", 32'(vld_cnt), 32'd1);
        check("perr_ferr", 32'(ferr_cnt), 32'd0);
        check("perr_rx_hold", 32'(rx_data), 32'hA5);

        // Framing error: 0x55, good parity, stop 0, then line high
        busy_cyc = 0;
        send_frame(8'h55, 1'b0, 1'b0);
        idle(15);
        check("ferr_cnt", 32'(ferr_cnt), 32'd1);
        check("ferr_perr", 32'(perr_cnt), 32'd1);
        check("ferr_no_vld", 32'(vld_cnt), 32'd1);
        check("ferr_no_phantom", 32'(busy_cyc), 32'd10);
        check("ferr_rx_hold", 32'(rx_data), 32'hA5);

        // Back-to-back: 0x01 (parity 1) then 0xFF (parity 0)
        exp_q.push_back(32'h01);
        exp_q.push_back(32'hFF);
        send_frame(8'h01, 1'b1, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1);
        idle(3);
        check("b2b_vld_cnt", 32'(vld_cnt), 32'd3);
        check("b2b_spacing", 32'(vld_cyc - prev_vld_cyc), 32'd11);
        check("b2b_rx_data", 32'(rx_data), 32'hFF);
        check("b2b_errs", 32'(perr_cnt + ferr_cnt), 32'd2);

        // Reset mid-frame after 4 data bits of 0xC3
        drive(START_BIT);
        drive(1'b1); drive(1'b1); drive(1'b0); drive(1'b0);
        @(posedge clk);
        #1 rstn = 1'b0;
        #1;
        check("mrst_rx_data", 32'(rx_data), 32'h0);
        check("mrst_busy", 32'(busy), 32'h0);
        check("mrst_pulses", 32'({rx_vld, par_err, frm_err}), 32'h0);
        din = 1'b1;
        v0 = vld_cnt; p0 = perr_cnt; f0 = ferr_cnt;
        @(posedge clk);
        #1 rstn = 1'b1;
        idle(20);
        #1;
        check("mrst_after_vld", 32'(vld_cnt), 32'(v0));
        check("mrst_after_perr", 32'(perr_cnt), 32'(p0));
        check("mrst_after_ferr", 32'(ferr_cnt), 32'(f0));
        check("mrst_after_busy", 32'(busy), 32'h0);

        // DATA_W=5, no parity: bits 1,1,0,0,1 -> 0x13
        d5 = 5'h13;
        exp5_q.push_back(32'h13);
        @(posedge clk);
        #1 din5 = START_BIT;
        start_cyc = cyc;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1 din5 = d5[i];
        end
        @(posedge clk);
        #1 din5 = STOP_BIT;
        repeat (4) @(posedge clk);
        #1;
        check("d5_vld_cnt", 32'(vld5_cnt), 32'd1);
        check("d5_latency", 32'(vld5_cyc - start_cyc), 32'd7);
        check("d5_rx_data", 32'(rx_data5), 32'h13);
        check("d5_no_perr", 32'(perr5_cnt), 32'd0);
        check("d5_busy_end", 32'(busy5), 32'd0);

        check("sb_drained", 32'(exp_q.size() + exp5_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
